// File: rtl/ysyx_210544_wb_scoreboard_pkg.sv
// Shared types and constants for the write-back scoreboard slice.
// Holds the register-index/data bus types, the output-stage record and a popcount helper.
package ysyx_210544_wb_scoreboard_pkg;

  localparam int NREGS  = 32;
  localparam int XLEN   = 64;
  localparam int RIDX_W = 5;

  typedef logic [RIDX_W-1:0] BUS_RIDX;
  typedef logic [XLEN-1:0]   BUS_64;

  localparam BUS_64 ZERO_WORD = '0;

  typedef struct packed {
    logic    wen;
    BUS_RIDX rd;
    BUS_64   data;
  } wb_t;

  function automatic logic [5:0] popcnt32(input logic [NREGS-1:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < NREGS; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/ysyx_210544_rr_arb2.sv
// Two-way round-robin arbiter, combinational grant; the priority flop flips after every grant.
// Grants are forced low while rst is high; requesters hold their request until granted.
module ysyx_210544_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // prio1_q = 1 means requester 1 wins a tie (requester 0 was granted last)
  logic prio1_q, prio1_d;

  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    if (!rst) begin
      if (req0_i && (!req1_i || !prio1_q)) begin
        gnt0_o = 1'b1;
      end else if (req1_i) begin
        gnt1_o = 1'b1;
      end
    end
  end

  always_comb begin
    prio1_d = prio1_q;
    if (gnt0_o) begin
      prio1_d = 1'b1;
    end else if (gnt1_o) begin
      prio1_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio1_q <= 1'b0;
    end else begin
      prio1_q <= prio1_d;
    end
  end

endmodule

// File: rtl/ysyx_210544_wb_scoreboard.sv
// Register-file write-back controller: busy bitmap with RAW/WAW issue stall, ALU/LSU round-robin.
// Grant in T drives the regfile write in T+1; busy clears on that same edge; issue stalls via o_issue_ready.
module ysyx_210544_wb_scoreboard
  import ysyx_210544_wb_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_issue_valid,
  input  BUS_RIDX       i_issue_rs1,
  input  logic          i_issue_rs1_ren,
  input  BUS_RIDX       i_issue_rs2,
  input  logic          i_issue_rs2_ren,
  input  BUS_RIDX       i_issue_rd,
  input  logic          i_issue_rd_wen,
  output logic          o_issue_ready,
  input  logic          i_alu_valid,
  input  BUS_RIDX       i_alu_rd,
  input  BUS_64         i_alu_data,
  output logic          o_alu_ready,
  input  logic          i_lsu_valid,
  input  BUS_RIDX       i_lsu_rd,
  input  BUS_64         i_lsu_data,
  output logic          o_lsu_ready,
  output BUS_RIDX       o_rd,
  output logic          o_rd_wen,
  output BUS_64         o_rd_data,
  output logic [NREGS-1:0] o_busy,
  output logic [5:0]    o_pending_cnt,
  output logic          o_idle
);

  logic [NREGS-1:0] busy_q, busy_d, set_vec, clr_vec;
  wb_t              wb_q, wb_d;
  logic             alu_gnt, lsu_gnt, hazard;

  ysyx_210544_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0_i (i_alu_valid),
    .req1_i (i_lsu_valid),
    .gnt0_o (alu_gnt),
    .gnt1_o (lsu_gnt)
  );

  // No bypass of a same-cycle clear: readiness looks only at the registered bitmap
  assign hazard = (i_issue_rs1_ren && busy_q[i_issue_rs1])
               || (i_issue_rs2_ren && busy_q[i_issue_rs2])
               || (i_issue_rd_wen  && busy_q[i_issue_rd]);

  assign o_issue_ready = !rst && !hazard;
  assign o_alu_ready   = alu_gnt;
  assign o_lsu_ready   = lsu_gnt;

  always_comb begin
    wb_d     = wb_q;
    wb_d.wen = 1'b0;
    if (alu_gnt) begin
      wb_d = '{wen: (i_alu_rd != '0), rd: i_alu_rd, data: i_alu_data};
    end else if (lsu_gnt) begin
      wb_d = '{wen: (i_lsu_rd != '0), rd: i_lsu_rd, data: i_lsu_data};
    end
  end

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (i_issue_valid && o_issue_ready && i_issue_rd_wen && (i_issue_rd != '0)) begin
      set_vec[i_issue_rd] = 1'b1;
    end
    if (wb_q.wen) begin
      clr_vec[wb_q.rd] = 1'b1;
    end
    // Set is applied after clear so it wins on a collision; flush overrides both
    busy_d    = i_flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      wb_q   <= '{wen: 1'b0, rd: '0, data: ZERO_WORD};
    end else begin
      busy_q <= busy_d;
      wb_q   <= wb_d;
    end
  end

  assign o_rd          = wb_q.rd;
  assign o_rd_wen      = wb_q.wen;
  assign o_rd_data     = wb_q.data;
  assign o_busy        = busy_q;
  assign o_pending_cnt = popcnt32(busy_q);
  assign o_idle        = (busy_q == '0) && !wb_q.wen && !i_alu_valid && !i_lsu_valid;

endmodule

// File: tb/tb_ysyx_210544_wb_scoreboard.sv
// Bench for the write-back scoreboard: directed scenarios plus a randomized run vs a reference model.
module tb_ysyx_210544_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst, i_flush;
  logic        i_issue_valid, i_issue_rs1_ren, i_issue_rs2_ren, i_issue_rd_wen;
  logic [4:0]  i_issue_rs1, i_issue_rs2, i_issue_rd;
  logic        o_issue_ready;
  logic        i_alu_valid, o_alu_ready, i_lsu_valid, o_lsu_ready;
  logic [4:0]  i_alu_rd, i_lsu_rd, o_rd;
  logic [63:0] i_alu_data, i_lsu_data, o_rd_data;
  logic        o_rd_wen, o_idle;
  logic [31:0] o_busy;
  logic [5:0]  o_pending_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state: set of busy registers, pending write, who wins the next tie
  bit [31:0] m_busy;
  bit        m_wen;
  bit [4:0]  m_rd;
  bit [63:0] m_data;
  bit        m_alu_next;
  bit        m_last_ga, m_last_gl;

  always #5 clk = ~clk;

  ysyx_210544_wb_scoreboard dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_issue_valid(i_issue_valid), .i_issue_rs1(i_issue_rs1), .i_issue_rs1_ren(i_issue_rs1_ren),
    .i_issue_rs2(i_issue_rs2), .i_issue_rs2_ren(i_issue_rs2_ren), .i_issue_rd(i_issue_rd),
    .i_issue_rd_wen(i_issue_rd_wen), .o_issue_ready(o_issue_ready),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data), .o_alu_ready(o_alu_ready),
    .i_lsu_valid(i_lsu_valid), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data), .o_lsu_ready(o_lsu_ready),
    .o_rd(o_rd), .o_rd_wen(o_rd_wen), .o_rd_data(o_rd_data), .o_busy(o_busy),
    .o_pending_cnt(o_pending_cnt), .o_idle(o_idle)
  );

  function automatic bit m_ready();
    if (rst) return 1'b0;
    if (i_issue_rs1_ren && m_busy[i_issue_rs1]) return 1'b0;
    if (i_issue_rs2_ren && m_busy[i_issue_rs2]) return 1'b0;
    if (i_issue_rd_wen && m_busy[i_issue_rd]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_gnt_alu();
    if (rst || !i_alu_valid) return 1'b0;
    return !i_lsu_valid || m_alu_next;
  endfunction

  function automatic bit m_gnt_lsu();
    if (rst || !i_lsu_valid) return 1'b0;
    return !i_alu_valid || !m_alu_next;
  endfunction

  // Advance the model by one clock using the currently driven inputs, then step the DUT
  task automatic tick();
    bit ga, gl, rdy;
    bit [31:0] nb;
    ga = m_gnt_alu();
    gl = m_gnt_lsu();
    rdy = m_ready();
    if (rst) begin
      m_busy = '0; m_wen = 0; m_rd = '0; m_data = '0; m_alu_next = 1;
    end else begin
      nb = m_busy;
      if (m_wen) nb[m_rd] = 1'b0;
      if (i_issue_valid && rdy && i_issue_rd_wen && i_issue_rd != 0) nb[i_issue_rd] = 1'b1;
      if (i_flush) nb = '0;
      if (ga) begin
        m_wen = (i_alu_rd != 0); m_rd = i_alu_rd; m_data = i_alu_data; m_alu_next = 0;
      end else if (gl) begin
        m_wen = (i_lsu_rd != 0); m_rd = i_lsu_rd; m_data = i_lsu_data; m_alu_next = 1;
      end else begin
        m_wen = 0;
      end
      m_busy = nb;
    end
    m_last_ga = ga;
    m_last_gl = gl;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_flush = 0; i_issue_valid = 0; i_issue_rs1 = 0; i_issue_rs1_ren = 0;
    i_issue_rs2 = 0; i_issue_rs2_ren = 0; i_issue_rd = 0; i_issue_rd_wen = 0;
    i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
    i_lsu_valid = 0; i_lsu_rd = 0; i_lsu_data = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1; tick();
    rst = 0;
  endtask

  task automatic issue_dst(input logic [4:0] rd);
    i_issue_valid = 1; i_issue_rd = rd; i_issue_rd_wen = 1;
    i_issue_rs1_ren = 0; i_issue_rs2_ren = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    i_issue_valid = 1; i_issue_rd = 3; i_issue_rd_wen = 1;
    i_alu_valid = 1; i_alu_rd = 4; i_lsu_valid = 1; i_lsu_rd = 6;
    #2;
    checks++; if (o_issue_ready !== 1'b0) begin failures++; $display("FAIL rst_issue_ready act=%b exp=0", o_issue_ready); end
    checks++; if (o_alu_ready !== 1'b0) begin failures++; $display("FAIL rst_alu_ready act=%b exp=0", o_alu_ready); end
    checks++; if (o_lsu_ready !== 1'b0) begin failures++; $display("FAIL rst_lsu_ready act=%b exp=0", o_lsu_ready); end
    tick(); tick();
    rst = 0; clear_inputs();
    #2;
    checks++; if (o_busy !== 32'h0) begin failures++; $display("FAIL rst_busy act=%h exp=0", o_busy); end
    checks++; if (o_rd_wen !== 1'b0 || o_rd !== 5'd0 || o_rd_data !== 64'h0) begin
      failures++; $display("FAIL rst_outstage act=%b/%0d/%h exp=0/0/0", o_rd_wen, o_rd, o_rd_data); end
    checks++; if (o_pending_cnt !== 6'd0 || o_idle !== 1'b1) begin
      failures++; $display("FAIL rst_idle act=cnt%0d idle%b exp=cnt0 idle1", o_pending_cnt, o_idle); end
  endtask

  task automatic test_raw_writeback();
    do_reset();
    issue_dst(5);
    #2;
    checks++; if (o_issue_ready !== 1'b1) begin failures++; $display("FAIL raw_first_ready act=%b exp=1", o_issue_ready); end
    tick();
    i_issue_rd_wen = 0; i_issue_rs1 = 5; i_issue_rs1_ren = 1;
    i_alu_valid = 1; i_alu_rd = 5; i_alu_data = 64'h1234;
    #2;
    checks++; if (o_busy !== 32'h20 || o_pending_cnt !== 6'd1) begin
      failures++; $display("FAIL raw_busy_set act=%h/%0d exp=00000020/1", o_busy, o_pending_cnt); end
    checks++; if (o_issue_ready !== 1'b0) begin failures++; $display("FAIL raw_stall act=%b exp=0", o_issue_ready); end
    checks++; if (o_alu_ready !== 1'b1) begin failures++; $display("FAIL raw_alu_grant act=%b exp=1", o_alu_ready); end
    tick();
    i_alu_valid = 0;
    #2;
    checks++; if (o_rd_wen !== 1'b1 || o_rd !== 5'd5 || o_rd_data !== 64'h1234) begin
      failures++; $display("FAIL raw_write act=%b/%0d/%h exp=1/5/1234", o_rd_wen, o_rd, o_rd_data); end
    checks++; if (o_issue_ready !== 1'b0 || o_busy !== 32'h20) begin
      failures++; $display("FAIL raw_no_bypass act=rdy%b busy%h exp=rdy0 busy00000020", o_issue_ready, o_busy); end
    tick();
    #2;
    checks++; if (o_issue_ready !== 1'b1 || o_busy !== 32'h0) begin
      failures++; $display("FAIL raw_release act=rdy%b busy%h exp=rdy1 busy0", o_issue_ready, o_busy); end
    clear_inputs(); tick();
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_rd [4];
    logic [63:0] exp_dat [4];
    exp_rd = '{5'd1, 5'd2, 5'd3, 5'd4};
    exp_dat = '{64'hA1, 64'hB2, 64'hA3, 64'hB4};
    do_reset();
    i_alu_valid = 1; i_alu_rd = 1; i_alu_data = 64'hA1;
    i_lsu_valid = 1; i_lsu_rd = 2; i_lsu_data = 64'hB2;
    for (int c = 0; c < 5; c++) begin
      #2;
      if (c < 4) begin
        checks++;
        if (o_alu_ready !== (c % 2 == 0) || o_lsu_ready !== (c % 2 == 1)) begin
          failures++; $display("FAIL b2b_grant c=%0d act=alu%b lsu%b exp=alu%b", c, o_alu_ready, o_lsu_ready, c % 2 == 0);
        end
      end
      if (c > 0) begin
        checks++;
        if (o_rd_wen !== 1'b1 || o_rd !== exp_rd[c-1] || o_rd_data !== exp_dat[c-1]) begin
          failures++; $display("FAIL b2b_write c=%0d act=%b/%0d/%h exp=1/%0d/%h", c, o_rd_wen, o_rd, o_rd_data, exp_rd[c-1], exp_dat[c-1]);
        end
      end
      tick();
      case (c)
        0: begin i_alu_rd = 3; i_alu_data = 64'hA3; end
        1: begin i_lsu_rd = 4; i_lsu_data = 64'hB4; end
        2: i_alu_valid = 0;
        3: i_lsu_valid = 0;
        default: ;
      endcase
    end
    #2;
    checks++; if (o_rd_wen !== 1'b0) begin failures++; $display("FAIL b2b_drain act=%b exp=0", o_rd_wen); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    issue_dst(0);
    #2;
    checks++; if (o_issue_ready !== 1'b1) begin failures++; $display("FAIL rd0_ready act=%b exp=1", o_issue_ready); end
    tick();
    clear_inputs();
    i_lsu_valid = 1; i_lsu_rd = 0; i_lsu_data = 64'hDEAD;
    #2;
    checks++; if (o_busy !== 32'h0) begin failures++; $display("FAIL rd0_busy act=%h exp=0", o_busy); end
    checks++; if (o_lsu_ready !== 1'b1) begin failures++; $display("FAIL rd0_lsu_grant act=%b exp=1", o_lsu_ready); end
    tick();
    i_lsu_valid = 0;
    #2;
    checks++; if (o_rd_wen !== 1'b0) begin failures++; $display("FAIL rd0_no_write act=%b exp=0", o_rd_wen); end
  endtask

  task automatic test_flush();
    do_reset();
    issue_dst(7); tick();
    issue_dst(9); tick();
    clear_inputs();
    #2;
    checks++; if (o_busy !== 32'h280 || o_pending_cnt !== 6'd2) begin
      failures++; $display("FAIL flush_pre act=%h/%0d exp=00000280/2", o_busy, o_pending_cnt); end
    i_flush = 1; i_alu_valid = 1; i_alu_rd = 7; i_alu_data = 64'h77;
    #2;
    checks++; if (o_alu_ready !== 1'b1) begin failures++; $display("FAIL flush_grant act=%b exp=1", o_alu_ready); end
    tick();
    clear_inputs();
    #2;
    checks++; if (o_busy !== 32'h0) begin failures++; $display("FAIL flush_busy act=%h exp=0", o_busy); end
    checks++; if (o_rd_wen !== 1'b1 || o_rd !== 5'd7 || o_rd_data !== 64'h77) begin
      failures++; $display("FAIL flush_write act=%b/%0d/%h exp=1/7/77", o_rd_wen, o_rd, o_rd_data); end
    tick();
    #2;
    checks++; if (o_busy !== 32'h0 || o_idle !== 1'b1) begin
      failures++; $display("FAIL flush_after act=%h idle%b exp=0 idle1", o_busy, o_idle); end
  endtask

  task automatic test_waw();
    do_reset();
    issue_dst(8); tick();
    #2;
    checks++; if (o_issue_ready !== 1'b0) begin failures++; $display("FAIL waw_stall0 act=%b exp=0", o_issue_ready); end
    tick();
    i_alu_valid = 1; i_alu_rd = 8; i_alu_data = 64'h88;
    #2;
    checks++; if (o_issue_ready !== 1'b0 || o_alu_ready !== 1'b1) begin
      failures++; $display("FAIL waw_stall1 act=rdy%b gnt%b exp=rdy0 gnt1", o_issue_ready, o_alu_ready); end
    tick();
    i_alu_valid = 0;
    #2;
    checks++; if (o_issue_ready !== 1'b0 || o_rd_wen !== 1'b1 || o_rd !== 5'd8) begin
      failures++; $display("FAIL waw_commit act=rdy%b wen%b rd%0d exp=rdy0 wen1 rd8", o_issue_ready, o_rd_wen, o_rd); end
    tick();
    #2;
    checks++; if (o_issue_ready !== 1'b1) begin failures++; $display("FAIL waw_release act=%b exp=1", o_issue_ready); end
    tick();
    clear_inputs();
    #2;
    checks++; if (o_busy !== 32'h100) begin failures++; $display("FAIL waw_reissue act=%h exp=00000100", o_busy); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    issue_dst(12); tick();
    clear_inputs();
    i_alu_valid = 1; i_alu_rd = 11; i_alu_data = 64'hBB; tick();
    i_alu_valid = 1; i_lsu_valid = 1; i_lsu_rd = 13; rst = 1;
    #2;
    checks++; if (o_rd_wen !== 1'b1 || o_alu_ready !== 1'b0 || o_lsu_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_pre act=wen%b alu%b lsu%b exp=wen1 alu0 lsu0", o_rd_wen, o_alu_ready, o_lsu_ready); end
    tick();
    rst = 0;
    #2;
    checks++; if (o_rd_wen !== 1'b0 || o_busy !== 32'h0) begin
      failures++; $display("FAIL rstmid_drop act=wen%b busy%h exp=wen0 busy0", o_rd_wen, o_busy); end
    checks++; if (o_alu_ready !== 1'b1 || o_lsu_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_ptr act=alu%b lsu%b exp=alu1 lsu0", o_alu_ready, o_lsu_ready); end
    tick();
    clear_inputs(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 149) == 0);
      i_flush = ($urandom_range(0, 39) == 0);
      i_issue_valid = $urandom_range(0, 1);
      i_issue_rs1 = 5'($urandom_range(0, 15)); i_issue_rs1_ren = $urandom_range(0, 1);
      i_issue_rs2 = 5'($urandom_range(0, 15)); i_issue_rs2_ren = $urandom_range(0, 1);
      i_issue_rd = 5'($urandom_range(0, 15));  i_issue_rd_wen = $urandom_range(0, 1);
      // Requesters only change their request once the previous one was granted
      if (!i_alu_valid || m_last_ga) begin
        i_alu_valid = $urandom_range(0, 1);
        i_alu_rd = 5'($urandom_range(0, 15)); i_alu_data = {$urandom, $urandom};
      end
      if (!i_lsu_valid || m_last_gl) begin
        i_lsu_valid = $urandom_range(0, 1);
        i_lsu_rd = 5'($urandom_range(0, 15)); i_lsu_data = {$urandom, $urandom};
      end
      #2;
      checks++; if (o_issue_ready !== m_ready()) begin
        failures++; $display("FAIL rnd_ready n=%0d act=%b exp=%b", n, o_issue_ready, m_ready()); end
      checks++; if (o_alu_ready !== m_gnt_alu() || o_lsu_ready !== m_gnt_lsu()) begin
        failures++; $display("FAIL rnd_grant n=%0d act=%b%b exp=%b%b", n, o_alu_ready, o_lsu_ready, m_gnt_alu(), m_gnt_lsu()); end
      checks++; if (o_rd_wen !== m_wen || (m_wen && (o_rd !== m_rd || o_rd_data !== m_data))) begin
        failures++; $display("FAIL rnd_write n=%0d act=%b/%0d/%h exp=%b/%0d/%h", n, o_rd_wen, o_rd, o_rd_data, m_wen, m_rd, m_data); end
      checks++; if (o_busy !== m_busy || o_pending_cnt !== 6'($countones(m_busy))) begin
        failures++; $display("FAIL rnd_busy n=%0d act=%h/%0d exp=%h/%0d", n, o_busy, o_pending_cnt, m_busy, $countones(m_busy)); end
      checks++; if (o_idle !== (m_busy == 0 && !m_wen && !i_alu_valid && !i_lsu_valid)) begin
        failures++; $display("FAIL rnd_idle n=%0d act=%b", n, o_idle); end
      tick();
    end
    rst = 0;
    clear_inputs(); tick();
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    m_busy = '0; m_wen = 0; m_rd = '0; m_data = '0; m_alu_next = 1;
    m_last_ga = 0; m_last_gl = 0;
    #1;
    test_reset();
    test_raw_writeback();
    test_back_to_back();
    test_rd_zero();
    test_flush();
    test_waw();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
